mem_bus_fabric: RTL

Parametrised memory-bus interconnect between one picorv32-style master port and `NUM_SLAVES` peripheral ports, all in the `clk` domain. It replaces the flat OR-combined ready/rdata bus, and adds the following:
- explicit address decode with one-hot per-slave `valid`;
- registered responses;
- a per-transaction timeout watchdog, so an unmapped or hung address can no longer stall the core;
- a sticky error/status register.

It sits between the core (or the output of `simple_clock_crossing`) and the peripherals.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/mem_bus_decoder.sv | 31 +++
 rtl/mem_bus_fabric.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory-bus fabric: FSM encoding, status-register
// bit positions and the default error read data.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam int ST_TIMEOUT   = 0;
  localparam int ST_DECERR    = 1;
  localparam int ST_SLAVE_LSB = 4;
  localparam int ST_COUNT_LSB = 8;

  localparam logic [31:0] DEFAULT_ERROR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_decoder.sv
// Combinational address decode: lowest-indexed matching slave wins, plus a
// separate flag for the two internal status-register addresses.
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter int                         NUM_SLAVES  = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE  = {32'h13000000, 32'h12000000,
                                                       32'h11000000, 32'h10000000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK  = {4{32'hFF000000}},
  parameter logic [31:0]                STATUS_ADDR = 32'h1F000000
) (
  input  logic [31:0] addr,
  output logic        hit,
  output logic [3:0]  idx,
  output logic        status_hit
);

  always_comb begin
    hit = 1'b0;
    idx = 4'd0;
    // Walk downwards so the lowest matching index is the one left standing.
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((addr & SLAVE_MASK[k*32 +: 32]) == SLAVE_BASE[k*32 +: 32]) begin
        hit = 1'b1;
        idx = 4'(k);
      end
    end
    status_hit = (addr == STATUS_ADDR) || (addr == STATUS_ADDR + 32'd4);
  end

endmodule

// File: rtl/mem_bus_fabric.sv
// Single-master memory-bus interconnect with one-hot slave selects, registered
// responses, a per-transaction timeout watchdog and a sticky error register.
module mem_bus_fabric
  import mem_bus_pkg::*;
#(
  parameter int                         NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE     = {32'h13000000, 32'h12000000,
                                                          32'h11000000, 32'h10000000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK     = {4{32'hFF000000}},
  parameter logic [31:0]                STATUS_ADDR    = 32'h1F000000,
  parameter int                         TIMEOUT_CYCLES = 255,
  parameter logic [31:0]                ERROR_RDATA    = DEFAULT_ERROR_RDATA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid_i,
  input  logic [31:0]              mem_addr_i,
  input  logic [31:0]              mem_wdata_i,
  input  logic [3:0]               mem_wstrb_i,
  output logic                     mem_ready_o,
  output logic [31:0]              mem_rdata_o,
  output logic [NUM_SLAVES-1:0]    s_valid_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  output logic [3:0]               s_wstrb_o,
  input  logic [NUM_SLAVES-1:0]    s_ready_i,
  input  logic [NUM_SLAVES*32-1:0] s_rdata_i,
  output logic                     err_irq_o
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         idx_q;
  logic [31:0]        rdata_q;
  logic               st_timeout;
  logic               st_decerr;
  logic [3:0]         err_slave;
  logic [15:0]        err_cnt;
  logic [31:0]        err_addr;

  logic               dec_hit;
  logic [3:0]         dec_idx;
  logic               dec_status_hit;
  logic               sel_ready;
  logic [31:0]        sel_rdata;
  logic               timeout_hit;
  logic [31:0]        status_word;

  mem_bus_decoder #(
    .NUM_SLAVES  (NUM_SLAVES),
    .SLAVE_BASE  (SLAVE_BASE),
    .SLAVE_MASK  (SLAVE_MASK),
    .STATUS_ADDR (STATUS_ADDR)
  ) u_dec (
    .addr       (mem_addr_i),
    .hit        (dec_hit),
    .idx        (dec_idx),
    .status_hit (dec_status_hit)
  );

  // Only the selected slave's ready counts, since s_valid_o is one-hot.
  assign sel_ready   = |(s_ready_i & s_valid_o);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt) + 32'd1) == 32'(TIMEOUT_CYCLES));
  assign err_irq_o   = st_timeout | st_decerr;

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == 4'(k)) sel_rdata = s_rdata_i[k*32 +: 32];
    end
    status_word = '0;
    status_word[ST_TIMEOUT]          = st_timeout;
    status_word[ST_DECERR]           = st_decerr;
    status_word[ST_SLAVE_LSB +: 4]   = err_slave;
    status_word[ST_COUNT_LSB +: 16]  = err_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      rdata_q     <= '0;
      st_timeout  <= 1'b0;
      st_decerr   <= 1'b0;
      err_slave   <= '0;
      err_cnt     <= '0;
      err_addr    <= '0;
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      s_valid_o   <= '0;
      s_addr_o    <= '0;
      s_wdata_o   <= '0;
      s_wstrb_o   <= '0;
    end else begin
      mem_ready_o <= 1'b0;
      mem_rdata_o <= '0;
      case (state)
        S_IDLE: begin
          // The master still holds valid during the ready cycle; don't re-accept it.
          if (mem_valid_i && !mem_ready_o) begin
            s_addr_o  <= mem_addr_i;
            s_wdata_o <= mem_wdata_i;
            s_wstrb_o <= mem_wstrb_i;
            if (dec_status_hit) begin
              state <= S_RESP;
              if (mem_wstrb_i != 4'b0) begin
                rdata_q <= '0;
                if (mem_addr_i == STATUS_ADDR) begin
                  if (mem_wdata_i[ST_TIMEOUT]) st_timeout <= 1'b0;
                  if (mem_wdata_i[ST_DECERR])  st_decerr  <= 1'b0;
                  if (mem_wdata_i[31])         err_cnt    <= '0;
                end
              end else begin
                rdata_q <= (mem_addr_i == STATUS_ADDR) ? status_word : err_addr;
              end
            end else if (dec_hit) begin
              s_valid_o <= NUM_SLAVES'(1) << dec_idx;
              idx_q     <= dec_idx;
              cnt       <= '0;
              state     <= S_ACTIVE;
            end else begin
              st_decerr <= 1'b1;
              err_addr  <= mem_addr_i;
              err_cnt   <= sat_inc(err_cnt);
              rdata_q   <= ERROR_RDATA;
              state     <= S_RESP;
            end
          end
        end
        S_ACTIVE: begin
          if (sel_ready) begin
            rdata_q   <= sel_rdata;
            s_valid_o <= '0;
            state     <= S_RESP;
          end else if (timeout_hit) begin
            st_timeout <= 1'b1;
            err_slave  <= idx_q;
            err_addr   <= s_addr_o;
            err_cnt    <= sat_inc(err_cnt);
            rdata_q    <= ERROR_RDATA;
            s_valid_o  <= '0;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          mem_ready_o <= 1'b1;
          mem_rdata_o <= rdata_q;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
